scrambler_datapath: RTL

- Downstream consumer of primary_lfsr_5. Takes a 32-bit word stream on a valid/ready handshake and XORs each word with lfsr_dout[31:0].
- Pulses lfsr_enable once per scrambled word, so the LFSR advances one 15-step burst per word.
- Frames are delimited by in_sof plus a programmed frame length.
- Control lives on the shared addr/write register bus, next to the LFSR seed words at 0x0a4/0x0a5.

---
 rtl/scrambler_pkg.sv | 23 ++
 rtl/scrambler_datapath_if.sv | 30 +++
 rtl/skid_buffer_2.sv | 68 ++++++
 rtl/scrambler_datapath.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/scrambler_pkg.sv
// Shared constants for the scrambler datapath: register map, CTRL bit layout, frame FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scrambler_pkg;

    // Register map on the shared addr/write bus. The seed words belong to the LFSR block.
    localparam logic [11:0] LFSR_W0_ADDR = 12'h0a4;
    localparam logic [11:0] LFSR_W1_ADDR = 12'h0a5;
    localparam logic [11:0] CTRL_ADDR    = 12'h0a6;
    localparam logic [11:0] LEN_ADDR     = 12'h0a7;

    // CTRL register bit positions
    localparam int CTRL_SCR_EN  = 0;
    localparam int CTRL_BYPASS  = 1;
    localparam int CTRL_CLR_ERR = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/scrambler_datapath_if.sv
// Input and output word streams of the scrambler datapath, grouped as one bundle.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both streams.
//   in_*  : upstream -> block (in_ready flows back)
//   out_* : block -> downstream (out_ready flows back)
interface scrambler_datapath_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_sof;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sof;
    logic                  out_eof;

    // The scrambler block itself
    modport slave (
        input  in_valid, in_data, in_sof, out_ready,
        output in_ready, out_valid, out_data, out_sof, out_eof
    );

    // Whoever feeds and drains the block
    modport master (
        output in_valid, in_data, in_sof, out_ready,
        input  in_ready, out_valid, out_data, out_sof, out_eof
    );
endinterface

// File: rtl/skid_buffer_2.sv
// Generic 2-entry valid/ready buffer: output register plus one skid register.
// Latency: 1 cycle from in accept to out_vld; full throughput while out_rdy=1.
// Backpressure: in_rdy drops only when the skid entry is occupied; out_* held while stalled.
//   in_vld/in_rdy/in_dat   : write side
//   out_vld/out_rdy/out_dat: read side
//   empty                  : both entries free
module skid_buffer_2 #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic             empty
);
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_dat_q, out_dat_d;
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] skid_dat_q, skid_dat_d;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (!out_vld_q || out_rdy) begin
            // Output slot frees up: the oldest word (skid) moves forward first.
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_dat_d  = skid_dat_q;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = in_vld;
                if (in_vld) begin
                    out_dat_d = in_dat;
                end
            end
        end else if (in_vld && !skid_vld_q) begin
            // Output stalled: park the new word in the skid slot.
            skid_vld_d = 1'b1;
            skid_dat_d = in_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
        end
    end

    assign in_rdy  = !skid_vld_q;
    assign out_vld = out_vld_q;
    assign out_dat = out_dat_q;
    assign empty   = !out_vld_q && !skid_vld_q;

endmodule

// File: rtl/scrambler_datapath.sv
// Frame-aware word scrambler: XORs payload with LFSR state and steps the LFSR once per word.
// Latency: 1 cycle accept-to-out_valid; 1 word/cycle while out_ready=1.
// Backpressure: 2-entry skid buffer; in_ready low when skid full or while a frame drains.
//   clk/rst               : single clock, synchronous active-high reset
//   write/addr/wdata      : register bus (CTRL, LEN)
//   lfsr_dout/lfsr_enable : LFSR state in, advance request out
//   io (slave)            : input and output word streams
//   busy/frame_done/sof_err: status
module scrambler_datapath #(
    parameter int          DATA_WIDTH = 32,
    parameter int          POLY_WIDTH = 43,
    parameter int          LEN_WIDTH  = 16,
    parameter logic [11:0] CTRL_ADDR  = scrambler_pkg::CTRL_ADDR,
    parameter logic [11:0] LEN_ADDR   = scrambler_pkg::LEN_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic [11:0]           addr,
    input  logic [31:0]           wdata,
    input  logic [POLY_WIDTH-1:0] lfsr_dout,
    output logic                  lfsr_enable,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  sof_err,
    scrambler_datapath_if.slave   io
);
    import scrambler_pkg::*;

    localparam int PAY_W = DATA_WIDTH + 2;

    state_t               state_q, state_d;
    logic                 scr_en_q, scr_en_d;
    logic                 bypass_q, bypass_d;
    logic [LEN_WIDTH-1:0] len_reg_q, len_reg_d;   // programmed LEN register
    logic [LEN_WIDTH-1:0] len_q, len_d;           // length of the frame in flight
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic                 sof_err_q, sof_err_d;
    logic                 frame_done_q, frame_done_d;

    logic                  buf_in_rdy, buf_out_vld, buf_empty;
    logic [PAY_W-1:0]      buf_out_dat;
    logic                  acc, start, mid, scrambling, clr_err, set_err;
    logic                  word_sof, word_eof;
    logic [LEN_WIDTH-1:0]  eff_len;
    logic [DATA_WIDTH-1:0] word_dat;

    // Upper wdata bits and the LFSR bits beyond the payload width are not consumed.
    logic unused_bits;
    assign unused_bits = ^{wdata, lfsr_dout};

    assign io.in_ready = buf_in_rdy && (state_q != DRAIN);
    assign acc         = io.in_valid && io.in_ready;

    // Framing decode for the word being accepted this cycle
    always_comb begin
        eff_len    = (len_reg_q == '0) ? LEN_WIDTH'(1) : len_reg_q;
        start      = (state_q == IDLE) && acc && io.in_sof && scr_en_q;
        mid        = (state_q == ACTIVE) && acc;
        scrambling = start || mid;
        word_sof   = start;
        word_eof   = 1'b0;
        if (start) begin
            word_eof = (eff_len == LEN_WIDTH'(1));
        end else if (mid) begin
            word_eof = (count_q == len_q - LEN_WIDTH'(1));
        end
        word_dat = io.in_data;
        if (scrambling && !bypass_q) begin
            word_dat = io.in_data ^ lfsr_dout[DATA_WIDTH-1:0];
        end
    end

    // The LFSR steps on the same edge that captures word_dat, so the next word sees fresh state.
    assign lfsr_enable = scrambling && !bypass_q;

    always_comb begin
        state_d      = state_q;
        scr_en_d     = scr_en_q;
        bypass_d     = bypass_q;
        len_reg_d    = len_reg_q;
        len_d        = len_q;
        count_d      = count_q;
        frame_done_d = 1'b0;
        clr_err      = 1'b0;
        set_err      = 1'b0;

        if (write && (addr == CTRL_ADDR)) begin
            scr_en_d = wdata[CTRL_SCR_EN];
            bypass_d = wdata[CTRL_BYPASS];
            clr_err  = wdata[CTRL_CLR_ERR];
        end
        if (write && (addr == LEN_ADDR)) begin
            len_reg_d = wdata[LEN_WIDTH-1:0];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = eff_len;
                    count_d = LEN_WIDTH'(1);
                    state_d = word_eof ? DRAIN : ACTIVE;
                end
            end
            ACTIVE: begin
                if (mid) begin
                    // A stray SOF is flagged but otherwise treated as a payload word.
                    set_err = io.in_sof;
                    count_d = count_q + LEN_WIDTH'(1);
                    if (word_eof) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (buf_empty) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new error in the same cycle as a clear keeps the flag set.
        sof_err_d = (sof_err_q && !clr_err) || set_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            scr_en_q     <= 1'b0;
            bypass_q     <= 1'b0;
            len_reg_q    <= '0;
            len_q        <= '0;
            count_q      <= '0;
            sof_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            scr_en_q     <= scr_en_d;
            bypass_q     <= bypass_d;
            len_reg_q    <= len_reg_d;
            len_q        <= len_d;
            count_q      <= count_d;
            sof_err_q    <= sof_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    skid_buffer_2 #(
        .WIDTH (PAY_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (acc),
        .in_rdy  (buf_in_rdy),
        .in_dat  ({word_sof, word_eof, word_dat}),
        .out_vld (buf_out_vld),
        .out_rdy (io.out_ready),
        .out_dat (buf_out_dat),
        .empty   (buf_empty)
    );

    assign io.out_valid = buf_out_vld;
    assign io.out_sof   = buf_out_dat[PAY_W-1];
    assign io.out_eof   = buf_out_dat[PAY_W-2];
    assign io.out_data  = buf_out_dat[DATA_WIDTH-1:0];
    assign busy         = (state_q != IDLE);
    assign frame_done   = frame_done_q;
    assign sof_err      = sof_err_q;

endmodule
